// File: rtl/rf_core_pkg.sv
// Shared types and constants for the GPR file and its pending-write scoreboard.
package rf_core_pkg;

  localparam int NREG       = 32;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 2;
  localparam int ADDR_W     = $clog2(NREG);
  localparam int RF_CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [ADDR_W-1:0] creg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic       en;
    creg_addr_t addr;
    word_t      wd;
  } w_rf_r;

  // True when the writeback in flight this cycle targets register a.
  function automatic logic wr_hits(w_rf_r w, creg_addr_t a);
    return w.en && (w.addr == a);
  endfunction

endpackage

// File: rtl/rf_core_if.sv
// Decode/writeback side of the register file: read ports, writeback, issue and scoreboard status.
interface rf_core_if;
  import rf_core_pkg::*;

  creg_addr_t ra1;
  creg_addr_t ra2;
  word_t      src1;
  word_t      src2;
  logic       rdy1;
  logic       rdy2;
  w_rf_r      w;
  logic       issue_en;
  creg_addr_t issue_dst;
  logic       issue_ok;
  logic       flush;
  logic       pend_any;
  logic       sb_err;

  modport master (
    output ra1, ra2, w, issue_en, issue_dst, flush,
    input  src1, src2, rdy1, rdy2, issue_ok, pend_any, sb_err
  );

  modport slave (
    input  ra1, ra2, w, issue_en, issue_dst, flush,
    output src1, src2, rdy1, rdy2, issue_ok, pend_any, sb_err
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: operand readiness, issue back-pressure and error flag.
module rf_scoreboard
  import rf_core_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  input  w_rf_r      w,
  input  logic       issue_en,
  input  creg_addr_t issue_dst,
  input  logic       flush,
  output logic       rdy1,
  output logic       rdy2,
  output logic       issue_ok,
  output logic       pend_any,
  output logic       sb_err
);

  cnt_t            cnt_q [NREG];
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] nz;
  logic            err;

  always_comb begin
    issue_ok = (issue_dst == '0) || (cnt_q[issue_dst] != cnt_t'(RF_CNT_MAX));
    // A single outstanding write landing this cycle is already on the bypass path.
    rdy1 = (ra1 == '0) || (cnt_q[ra1] == '0) ||
           ((cnt_q[ra1] == cnt_t'(1)) && wr_hits(w, ra1));
    rdy2 = (ra2 == '0) || (cnt_q[ra2] == '0) ||
           ((cnt_q[ra2] == cnt_t'(1)) && wr_hits(w, ra2));
    for (int r = 0; r < NREG; r++) begin
      inc[r] = (r != 0) && issue_en && (issue_dst == creg_addr_t'(r)) && issue_ok;
      dec[r] = (r != 0) && wr_hits(w, creg_addr_t'(r)) && (cnt_q[r] != '0);
      nz[r]  = (cnt_q[r] != '0);
    end
    err = !flush && ((issue_en && !issue_ok) ||
                     (w.en && (w.addr != '0) && (cnt_q[w.addr] == '0)));
  end

  assign pend_any = |nz;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      if (err) sb_err <= 1'b1;
      for (int r = 0; r < NREG; r++) begin
        if (flush)                 cnt_q[r] <= '0;
        else if (inc[r] && !dec[r]) cnt_q[r] <= cnt_q[r] + cnt_t'(1);
        else if (dec[r] && !inc[r]) cnt_q[r] <= cnt_q[r] - cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/rf_core.sv
// 32x32 GPR file with r0 hardwired to zero, same-cycle writeback bypass on both read ports,
// and a pending-write scoreboard telling decode whether each operand is final.
module rf_core
  import rf_core_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  rf_core_if.slave rf
);

  word_t gpr [NREG];

  // NOTE: the array is reset explicitly because reads must return zero right after reset;
  // this keeps it in flops rather than a RAM macro, which has no reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) gpr[r] <= '0;
    end else if (rf.w.en && (rf.w.addr != '0)) begin
      gpr[rf.w.addr] <= rf.w.wd;
    end
  end

  // NOTE: defaults are assigned first so every path drives the outputs and no latch is inferred.
  always_comb begin
    rf.src1 = gpr[rf.ra1];
    if (wr_hits(rf.w, rf.ra1)) rf.src1 = rf.w.wd;
    if (rf.ra1 == '0)          rf.src1 = '0;

    rf.src2 = gpr[rf.ra2];
    if (wr_hits(rf.w, rf.ra2)) rf.src2 = rf.w.wd;
    if (rf.ra2 == '0)          rf.src2 = '0;
  end

  rf_scoreboard u_sb (
    .clk       (clk),
    .resetn    (resetn),
    .ra1       (rf.ra1),
    .ra2       (rf.ra2),
    .w         (rf.w),
    .issue_en  (rf.issue_en),
    .issue_dst (rf.issue_dst),
    .flush     (rf.flush),
    .rdy1      (rf.rdy1),
    .rdy2      (rf.rdy2),
    .issue_ok  (rf.issue_ok),
    .pend_any  (rf.pend_any),
    .sb_err    (rf.sb_err)
  );

endmodule

// File: tb/tb_rf_core.sv
// Self-checking bench for rf_core: directed scenarios plus random traffic against a
// behavioural model (plain arrays of values and integer pending counts).
module tb_rf_core;
  import rf_core_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  rf_core_if bus ();

  rf_core dut (
    .clk    (clk),
    .resetn (resetn),
    .rf     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  word_t reg_m [NREG];
  int    cnt_m [NREG];
  bit    err_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic word_t m_src(creg_addr_t a, w_rf_r w);
    if (a == 0) return '0;
    if (w.en && w.addr == a) return w.wd;
    return reg_m[a];
  endfunction

  function automatic logic m_rdy(creg_addr_t a, w_rf_r w);
    if (a == 0) return 1'b1;
    if (cnt_m[a] == 0) return 1'b1;
    return (cnt_m[a] == 1) && w.en && (w.addr == a);
  endfunction

  function automatic logic m_issue_ok(creg_addr_t d);
    return (d == 0) || (cnt_m[d] < RF_CNT_MAX);
  endfunction

  function automatic logic m_pend();
    foreach (cnt_m[i]) if (cnt_m[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    foreach (reg_m[i]) begin
      reg_m[i] = '0;
      cnt_m[i] = 0;
    end
    err_m = 1'b0;
  endtask

  // Applies one clock edge of the currently driven inputs to the model.
  task automatic model_commit();
    bit do_inc;
    bit do_dec;
    do_inc = bus.issue_en && bus.issue_dst != 0 && m_issue_ok(bus.issue_dst);
    do_dec = bus.w.en && bus.w.addr != 0 && cnt_m[bus.w.addr] > 0;
    if (bus.w.en && bus.w.addr != 0) reg_m[bus.w.addr] = bus.w.wd;
    if (bus.flush) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
    end else begin
      if (bus.issue_en && !m_issue_ok(bus.issue_dst)) err_m = 1'b1;
      if (bus.w.en && bus.w.addr != 0 && cnt_m[bus.w.addr] == 0) err_m = 1'b1;
      if (do_inc) cnt_m[bus.issue_dst] += 1;
      if (do_dec) cnt_m[bus.w.addr] -= 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".src1"},     bus.src1,     m_src(bus.ra1, bus.w));
    check({tag, ".src2"},     bus.src2,     m_src(bus.ra2, bus.w));
    check({tag, ".rdy1"},     32'(bus.rdy1),     32'(m_rdy(bus.ra1, bus.w)));
    check({tag, ".rdy2"},     32'(bus.rdy2),     32'(m_rdy(bus.ra2, bus.w)));
    check({tag, ".issue_ok"}, 32'(bus.issue_ok), 32'(m_issue_ok(bus.issue_dst)));
    check({tag, ".pend_any"}, 32'(bus.pend_any), 32'(m_pend()));
    check({tag, ".sb_err"},   32'(bus.sb_err),   32'(err_m));
  endtask

  // Drive one cycle of inputs, check mid-cycle, then clock it into DUT and model.
  task automatic step(input string tag, input creg_addr_t a1, input creg_addr_t a2,
                      input logic ie, input creg_addr_t idst,
                      input logic we, input creg_addr_t wa, input word_t wd,
                      input logic fl);
    bus.ra1       = a1;
    bus.ra2       = a2;
    bus.issue_en  = ie;
    bus.issue_dst = idst;
    bus.w         = '{en: we, addr: wa, wd: wd};
    bus.flush     = fl;
    #2;
    check_outputs(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle while a writeback to r6 is in flight.
  task automatic mid_reset(input string tag);
    bus.ra1      = 5'd5;
    bus.ra2      = 5'd0;
    bus.issue_en = 1'b0;
    bus.flush    = 1'b0;
    bus.w        = '{en: 1'b1, addr: 5'd6, wd: 32'hCAFE_F00D};
    #2;
    resetn = 1'b0;
    #1;
    check({tag, ".src1"},     bus.src1,          32'h0);
    check({tag, ".rdy1"},     32'(bus.rdy1),     32'd1);
    check({tag, ".pend_any"}, 32'(bus.pend_any), 32'd0);
    check({tag, ".sb_err"},   32'(bus.sb_err),   32'd0);
    check({tag, ".issue_ok"}, 32'(bus.issue_ok), 32'd1);
    @(posedge clk);
    bus.w = '0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ra1       = '0;
    bus.ra2       = '0;
    bus.issue_en  = 1'b0;
    bus.issue_dst = '0;
    bus.w         = '0;
    bus.flush     = 1'b0;
    model_reset();

    // Reset held: outputs in their reset state.
    bus.ra1 = 5'd5;
    #3;
    check("rst.src1",     bus.src1,          32'h0);
    check("rst.rdy1",     32'(bus.rdy1),     32'd1);
    check("rst.pend_any", 32'(bus.pend_any), 32'd0);
    check("rst.sb_err",   32'(bus.sb_err),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Reads and bypass.
    step("rd0",    5, 0, 0, 0, 0, 0, 32'h0,         0);
    step("byp",    5, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0);
    step("arr",    5, 5, 0, 0, 0, 0, 32'h0,         0);
    check("arr.src1_const", bus.src1, 32'hDEAD_BEEF);
    step("r0wr",   0, 5, 0, 0, 1, 0, 32'h0000_1234, 0);
    step("r0rd",   0, 0, 0, 0, 0, 0, 32'h0,         0);

    // Reset mid-operation; the in-flight write to r6 must be lost.
    mid_reset("mrst");
    step("lost",   6, 5, 0, 0, 0, 0, 32'h0,         0);

    // Scoreboard basics on r7.
    step("iss7",   7, 0, 1, 7, 0, 0, 32'h0,         0);
    step("pend7",  7, 7, 0, 0, 0, 0, 32'h0,         0);
    step("wb7",    7, 0, 0, 0, 1, 7, 32'h55,        0);
    step("done7",  7, 0, 0, 0, 0, 0, 32'h0,         0);

    // Saturation on r9, overflow attempt, then drain.
    for (int i = 0; i < 3; i++) step("sat",  9, 0, 1, 9, 0, 0, 32'h0, 0);
    step("ovf",    9, 0, 1, 9, 0, 0, 32'h0,         0);
    check("ovf.sb_err_const", 32'(bus.sb_err), 32'd1);
    for (int i = 0; i < 3; i++) step("drain", 9, 9, 0, 0, 1, 9, 32'(100 + i), 0);
    step("drained", 9, 0, 0, 0, 0, 0, 32'h0,       0);

    // Simultaneous issue and writeback on r4 with one pending.
    mid_reset("rst2");
    step("iss4",   4, 0, 1, 4, 0, 0, 32'h0,         0);
    step("sim4",   4, 0, 1, 4, 1, 4, 32'h44,        0);
    step("after4", 4, 0, 0, 0, 0, 0, 32'h0,         0);

    // Flush with r3 pending twice; write still commits.
    mid_reset("rst3");
    step("iss3a",  3, 0, 1, 3, 0, 0, 32'h0,         0);
    step("iss3b",  3, 0, 1, 3, 0, 0, 32'h0,         0);
    step("flush",  3, 0, 1, 8, 1, 3, 32'hA,         1);
    check("flush.pend_const", 32'(bus.pend_any), 32'd0);
    step("postfl", 3, 8, 0, 0, 0, 0, 32'h0,         0);
    step("unfl",   3, 0, 0, 0, 1, 3, 32'hB,         0);
    check("unfl.sb_err_const", 32'(bus.sb_err), 32'd1);

    // Random traffic, clustered on a few registers to force collisions.
    mid_reset("rst4");
    for (int i = 0; i < 1500; i++) begin
      creg_addr_t a1, a2, d, wa;
      a1 = creg_addr_t'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      a2 = creg_addr_t'($urandom_range(0, 7));
      d  = creg_addr_t'($urandom_range(0, 7));
      wa = creg_addr_t'($urandom_range(0, 7));
      step("rnd", a1, a2, 1'($urandom_range(0, 1)), d,
           1'($urandom_range(0, 1)), wa, word_t'($urandom),
           1'($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_core.md
Name: rf_core

Overview:
- Storage end of the register-file interface: 32x32 GPR array.
- Serves two combinational decode read ports and one writeback write port (w_rf_r).
- Adds a per-register pending-write scoreboard, so decode can tell whether an operand value is final.
- Sits between decode (ra1/ra2, src1/src2, issue) and writeback (w).

Parameters:
NREG, 32, number of GPRs; register 0 is hardwired to zero
DATA_W, 32, register width (equals word_t)
CNT_W, 2, width of the per-register pending counter; maximum in-flight writes per register = 2^CNT_W-1

Ports:
clk  in  1  core clock, all state updates on the rising edge
resetn  in  1  reset, asynchronous and active-low
ra1  in  5  read address port 1 (creg_addr_t)
ra2  in  5  read address port 2 (creg_addr_t)
src1  out  32  read data port 1 (word_t)
src2  out  32  read data port 2 (word_t)
rdy1  out  1  operand at ra1 has no outstanding write after this cycle
rdy2  out  1  same, for ra2
w  in  38  writeback request w_rf_r {en, addr[4:0], wd[31:0]}
issue_en  in  1  decode issues an instruction that will write issue_dst
issue_dst  in  5  destination register of the issued instruction
issue_ok  out  1  counter for issue_dst is not saturated (combinational)
flush  in  1  pipeline flush: discard all pending-write records
pend_any  out  1  some counter is non-zero (registered state)
sb_err  out  1  sticky scoreboard-error flag

Behaviour:
- Reset (resetn=0, asynchronous):
  - All GPRs = 0, all counters = 0, sb_err = 0.
  - Therefore src1/src2 = 0, rdy1/rdy2 = 1, issue_ok = 1, pend_any = 0 while reset is held.
- Write: at the rising edge, if w.en and w.addr != 0, then GPR[w.addr] <= w.wd. Writes to register 0 are ignored.
- Read is combinational, zero latency:
  - If ra == 0, src = 0.
  - Else if w.en and w.addr == ra, src = w.wd (same-cycle bypass).
  - Else src = GPR[ra].
  - Both ports are independent. ra1 == ra2 is legal and returns identical data.
- Ready:
  - rdy = 1 if ra == 0.
  - rdy = 1 if cnt[ra] == 0.
  - rdy = 1 if cnt[ra] == 1 and w.en and w.addr == ra (the last pending write lands now; value is on the bypass).
  - Otherwise rdy = 0.
  - flush does not affect rdy in the same cycle.
- issue_ok: 1 if issue_dst == 0; otherwise cnt[issue_dst] != max (3).
- Counter update per register r at the rising edge, in priority order:
  1. flush = 1: every counter <= 0. The register write still commits; issue and decrement are ignored.
  2. inc = issue_en and issue_dst == r and r != 0 and issue_ok.
     dec = w.en and w.addr == r and r != 0 and cnt[r] != 0.
     - inc and dec both set: counter unchanged.
     - Only inc: counter + 1.
     - Only dec: counter - 1.
- Error conditions, each setting sb_err <= 1 (sticky until reset):
  - issue_en with issue_ok = 0 (overflow attempt, no increment, flush = 0).
  - w.en and w.addr != 0 and cnt[w.addr] == 0 (underflow, counter stays 0, flush = 0).
  - In both cases the register write itself still happens.
- pend_any = OR over all counters. It reflects registered state (post-edge), not the in-cycle bypass.
- Reset mid-operation: state clears immediately, and an in-flight w is lost.
- No X propagation: all outputs are defined for any address value.

Decomposition:
- Shared package (global.svh): creg_addr_t, word_t, w_rf_r (already present), and the new constant RF_CNT_MAX.
- Sub-module rf_scoreboard holds the counter array, issue_ok, rdy logic, pend_any and sb_err.
- rf_core holds the GPR array and bypass muxes, and instantiates rf_scoreboard.
- rf_core connects to rf_intf's rf modport via a thin top-level binding.

Test Plan:
- Reset, then read ra1=5, ra2=0 -> src1=0, src2=0, rdy1=rdy2=1, pend_any=0, sb_err=0.
- w={1,5,32'hDEADBEEF} with ra1=5 in the same cycle -> src1=DEADBEEF (bypass); next cycle, w.en=0 -> src1=DEADBEEF from the array. w={1,0,32'h1234} -> src for ra=0 stays 0.
- Scoreboard basics:
  - issue_en, issue_dst=7 -> next cycle rdy1(ra1=7)=0, pend_any=1.
  - Then w={1,7,32'h55} -> same cycle rdy1=1, src1=55.
  - Next cycle cnt=0 and pend_any=0.
- Saturation: issue r9 three times -> issue_ok=0. A fourth issue -> sb_err=1 and the counter stays 3. Three writebacks to r9 -> rdy=1 coincides with the third writeback.
- Simultaneous issue_dst=4 and w.addr=4 with cnt=1 -> cnt remains 1, rdy(ra=4)=1 that cycle only.
- flush with cnt[3]=2 and w={1,3,32'hA} -> GPR[3]=A, all counters 0, pend_any=0 next cycle. Then w to r3 with no issue -> sb_err=1.
